bcd_scan_driver: RTL and testbench

//   Upstream feeder for the BCD-to-7-segment decoder in a 4-digit multiplexed display.

---
 rtl/bcd_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_bcd_scan_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Captures a 14-bit binary value and converts it to four BCD digits with a
//   sequential double-dabble, one bit per clock. Once a conversion finishes,
//   the result moves into the display registers. A free-running scanner
//   time-multiplexes those digits onto a single 4-bit bcd bus. Each digit has
//   an active-low anode enable, and leading zeros can optionally be blanked.

module bcd_scan_driver #(
  parameter int REFRESH_DIV = 1000,  // clocks each digit stays selected (>= 2)
  parameter bit LZ_BLANK    = 1'b1   // 1: blank leading zeros, digit 0 always lit
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  bcd,
  output logic [3:0]  anode
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST_SHIFT = 4'd13;   // 14 shifts: counts 0..13
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Converter state
  // ---------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [13:0] bin_work, bin_work_nxt;
  logic [15:0] bcd_work, bcd_work_nxt;
  logic [3:0]  shift_cnt, shift_cnt_nxt;
  logic        ovf_nxt;
  logic [15:0] disp, disp_nxt;

  // ---------------------------------------------------------------------
  // Scanner state
  // ---------------------------------------------------------------------
  logic [CW-1:0] refresh_cnt, refresh_cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [3:0]    anode_nxt;
  logic [3:0]    bcd_nxt;

  // Add 3 to every nibble that is >= 5. This is 4-bit arithmetic. Valid inputs
  // never let a nibble reach a value where the add would carry out.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int n = 0; n < 4; n++) begin
      if (v[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Check whether digit slot i should light. Digit 0 always lights. A higher
  // slot lights only if it, or some digit above it, is non-zero.
  function automatic logic digit_lit(input logic [15:0] d, input logic [1:0] i);
    logic lit;
    case (i)
      2'd0:    lit = 1'b1;
      2'd1:    lit = |d[15:4];
      2'd2:    lit = |d[15:8];
      default: lit = |d[15:12];
    endcase
    return lit;
  endfunction

  // Next-state and datapath logic for the IDLE -> SHIFT -> COMMIT sequence
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt     = state;
    bin_work_nxt  = bin_work;
    bcd_work_nxt  = bcd_work;
    shift_cnt_nxt = shift_cnt;
    ovf_nxt       = ovf;
    disp_nxt      = disp;

    case (state)
      IDLE: begin
        if (load) begin
          if (bin_in > MAX_VALUE) begin
            // Out-of-range request: flag it and leave the display alone.
            ovf_nxt = 1'b1;
          end else begin
            bin_work_nxt  = bin_in;
            bcd_work_nxt  = 16'h0000;
            shift_cnt_nxt = 4'd0;
            ovf_nxt       = 1'b0;
            state_nxt     = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Adjust first, then shift {bcd_work, bin_work} left by one bit.
        {bcd_work_nxt, bin_work_nxt} = {dabble_adjust(bcd_work)[14:0], bin_work, 1'b0};
        shift_cnt_nxt = shift_cnt + 4'd1;
        if (shift_cnt == LAST_SHIFT) state_nxt = COMMIT;
      end

      COMMIT: begin
        disp_nxt  = bcd_work;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Converter registers. busy and done are registered views of the state:
  // busy covers the 14 shift edges, and done fires on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin_work  <= 14'd0;
      bcd_work  <= 16'h0000;
      shift_cnt <= 4'd0;
      ovf       <= 1'b0;
      disp      <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, whatever the statement order.
      state     <= state_nxt;
      bin_work  <= bin_work_nxt;
      bcd_work  <= bcd_work_nxt;
      shift_cnt <= shift_cnt_nxt;
      ovf       <= ovf_nxt;
      disp      <= disp_nxt;
      busy      <= (state == SHIFT);
      done      <= (state == COMMIT);
    end
  end

  // Scanner next values. The digit outputs come from disp_nxt, so a commit
  // reaches the pins on the same edge the display registers change.
  always_comb begin
    refresh_cnt_nxt = refresh_cnt + CW'(1);
    idx_nxt         = idx;
    if (refresh_cnt == CNT_LAST) begin
      refresh_cnt_nxt = '0;
      idx_nxt         = idx + 2'd1;
    end

    bcd_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];

    if (LZ_BLANK && !digit_lit(disp_nxt, idx_nxt)) anode_nxt = 4'b1111;
    else                                           anode_nxt = ~(4'b0001 << idx_nxt);
  end

  // Scanner registers. The outputs are registered so the anode and bcd pins
  // stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      bcd         <= 4'h0;
      anode       <= 4'b1110;
    end else begin
      refresh_cnt <= refresh_cnt_nxt;
      idx         <= idx_nxt;
      bcd         <= bcd_nxt;
      anode       <= anode_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver
//   Randomised and directed stimulus checked against a decimal reference model.
//   Two instances are driven in parallel: one with leading-zero blanking and
//   one without.

module tb_bcd_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;

  logic       busy, done, ovf;
  logic [3:0] bcd, anode;
  logic       busy_nb, done_nb, ovf_nb;
  logic [3:0] bcd_nb, anode_nb;

  bcd_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .anode(anode)
  );

  bcd_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
    .busy(busy_nb), .done(done_nb), .ovf(ovf_nb), .bcd(bcd_nb), .anode(anode_nb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the display as a decimal number, plus time since reset.
  int m_edges;     // clock edges since reset was released
  int m_disp;      // value currently shown
  int m_pend;      // value under conversion
  int m_left;      // edges until commit; 0 means idle
  bit m_ovf;
  bit m_done;

  const int pow10[4] = '{1, 10, 100, 1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_disp  = 0;
    m_pend  = 0;
    m_left  = 0;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic check_outputs();
    int   slot;
    bit   lit;
    logic [3:0] dig;
    logic [3:0] sel;
    slot = (m_edges / DIV) % 4;
    dig  = 4'((m_disp / pow10[slot]) % 10);
    lit  = (slot == 0) || ((m_disp / pow10[slot]) != 0);
    sel  = ~(4'b0001 << slot);
    check("busy",     busy,     (m_left >= 1 && m_left <= 14));
    check("done",     done,     m_done);
    check("ovf",      ovf,      m_ovf);
    check("bcd",      bcd,      dig);
    check("anode",    anode,    lit ? sel : 4'b1111);
    check("bcd_nb",   bcd_nb,   dig);
    check("anode_nb", anode_nb, sel);
  endtask

  // Advance one clock with the current inputs, update the model, then compare.
  task automatic step();
    bit acc;
    int v;
    acc = (m_left == 0) && load;
    v   = int'(bin_in);
    @(posedge clk);
    #1;
    m_edges++;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_disp = m_pend;
        m_done = 1'b1;
      end
    end
    if (acc) begin
      if (v > 9999) m_ovf = 1'b1;
      else begin
        m_ovf  = 1'b0;
        m_pend = v;
        m_left = 15;
      end
    end
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int v);
    load   = 1'b1;
    bin_in = 14'(v);
    step();
    load   = 1'b0;
  endtask

  // Assert reset in mid-cycle, check the immediate effect, and release it on a negedge.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_anode", anode, 4'b1110);
    check("rst_bcd",   bcd,   4'h0);
    check("rst_busy",  busy,  1'b0);
    check("rst_ovf",   ovf,   1'b0);
    check("rst_done",  done,  1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = 14'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(20);

    // Reset in mid-cycle, then a free scan of the zero display.
    mid_reset();
    run(20);

    // Basic conversion.
    do_load(1234);
    run(32);

    // Full scale, then zero.
    do_load(9999);
    run(32);
    do_load(0);
    run(32);

    // Out-of-range value, then recovery.
    do_load(10000);
    run(8);
    do_load(5);
    run(32);

    // A load arriving while busy is ignored.
    do_load(4321);
    run(2);
    do_load(1111);
    run(32);

    // An internal zero with a blanked leading zero.
    do_load(405);
    run(32);

    // Reset while a conversion is in flight.
    do_load(8888);
    run(7);
    mid_reset();
    run(20);
    do_load(8888);
    run(32);

    // Random traffic, including out-of-range values and loads while busy.
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) bin_in = 14'($urandom_range(10000, 16383));
      else                           bin_in = 14'($urandom_range(0, 9999));
      step();
    end
    load = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
